// File: rtl/hazard3_dmi_async_initiator_pkg.sv
// Shared definitions for the DMI clock-crossing initiator: FSM encodings and launch-register layout.
// Request launch packs {addr, wdata, write}; response launch packs {rdata, err}.
package hazard3_dmi_async_initiator_pkg;

    typedef enum logic [1:0] {
        SRC_IDLE  = 2'd0,
        SRC_REQ   = 2'd1,
        SRC_ACKED = 2'd2,
        SRC_RSP   = 2'd3
    } src_state_t;

    typedef enum logic [1:0] {
        DST_IDLE   = 2'd0,
        DST_SETUP  = 2'd1,
        DST_ACCESS = 2'd2,
        DST_HOLD   = 2'd3
    } dst_state_t;

    localparam int unsigned DEF_W_ADDR = 8;
    localparam int unsigned DEF_W_DATA = 32;
    localparam int unsigned DEF_N_SYNC = 2;

    function automatic int unsigned req_launch_width(input int unsigned w_addr, input int unsigned w_data);
        return w_addr + w_data + 1;
    endfunction

    function automatic int unsigned rsp_launch_width(input int unsigned w_data);
        return w_data + 1;
    endfunction

endpackage

// File: rtl/hazard3_sync_1bit.sv
// Multi-flop level synchroniser; output follows input after N_STAGES destination clocks.
// Reset clears the chain to 0 so a reset domain never sees a stale handshake high.
module hazard3_sync_1bit #(
    parameter int unsigned N_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    (* keep = 1'b1 *) logic [N_STAGES-1:0] sync_flops;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_flops <= '0;
        end else begin
            sync_flops <= {sync_flops[N_STAGES-2:0], d};
        end
    end

    assign q = sync_flops[N_STAGES-1];

endmodule

// File: rtl/hazard3_dmi_async_initiator.sv
// Stream-to-APB DMI initiator across clk_src/clk_dst via a 4-phase req/ack handshake, one transfer in flight.
// Launch registers are held stable while the opposing side may sample them.
`ifndef HAZARD3_REG_KEEP_ATTRIBUTE
`define HAZARD3_REG_KEEP_ATTRIBUTE (* keep = 1'b1 *)
`endif

module hazard3_dmi_async_initiator
    import hazard3_dmi_async_initiator_pkg::*;
#(
    parameter int unsigned W_ADDR        = DEF_W_ADDR,
    parameter int unsigned W_DATA        = DEF_W_DATA,
    parameter int unsigned N_SYNC_STAGES = DEF_N_SYNC
) (
    input  logic              clk_src,
    input  logic              rst_n_src,
    input  logic              clk_dst,
    input  logic              rst_n_dst,

    input  logic              src_req_valid,
    output logic              src_req_ready,
    input  logic              src_req_write,
    input  logic [W_ADDR-1:0] src_req_addr,
    input  logic [W_DATA-1:0] src_req_wdata,

    output logic              src_rsp_valid,
    input  logic              src_rsp_ready,
    output logic [W_DATA-1:0] src_rsp_rdata,
    output logic              src_rsp_err,
    output logic              src_busy,

    output logic              dst_psel,
    output logic              dst_penable,
    output logic              dst_pwrite,
    output logic [W_ADDR-1:0] dst_paddr,
    output logic [W_DATA-1:0] dst_pwdata,
    input  logic [W_DATA-1:0] dst_prdata,
    input  logic              dst_pready,
    input  logic              dst_pslverr
);

    localparam int unsigned W_REQ = req_launch_width(W_ADDR, W_DATA);
    localparam int unsigned W_RSP = rsp_launch_width(W_DATA);

    src_state_t src_state;
    dst_state_t dst_state;
    logic       req;
    logic       ack;
    logic       req_sync;
    logic       ack_sync;

    `HAZARD3_REG_KEEP_ATTRIBUTE logic [W_REQ-1:0] req_launch;
    `HAZARD3_REG_KEEP_ATTRIBUTE logic [W_RSP-1:0] rsp_launch;

    hazard3_sync_1bit #(.N_STAGES(N_SYNC_STAGES)) u_sync_req (
        .clk   (clk_dst),
        .rst_n (rst_n_dst),
        .d     (req),
        .q     (req_sync)
    );

    hazard3_sync_1bit #(.N_STAGES(N_SYNC_STAGES)) u_sync_ack (
        .clk   (clk_src),
        .rst_n (rst_n_src),
        .d     (ack),
        .q     (ack_sync)
    );

    // Only loaded in IDLE, so it is frozen for the whole time req may be seen high by dst.
    always_ff @(posedge clk_src) begin
        if (src_state == SRC_IDLE && src_req_valid) begin
            req_launch <= {src_req_addr, src_req_wdata, src_req_write};
        end
    end

    always_ff @(posedge clk_src or negedge rst_n_src) begin
        if (!rst_n_src) begin
            src_state     <= SRC_IDLE;
            req           <= 1'b0;
            src_req_ready <= 1'b1;
            src_busy      <= 1'b0;
            src_rsp_valid <= 1'b0;
            src_rsp_rdata <= '0;
            src_rsp_err   <= 1'b0;
        end else begin
            case (src_state)
                SRC_IDLE: if (src_req_valid) begin
                    req           <= 1'b1;
                    src_req_ready <= 1'b0;
                    src_busy      <= 1'b1;
                    src_state     <= SRC_REQ;
                end
                SRC_REQ: if (ack_sync) begin
                    req       <= 1'b0;
                    src_state <= SRC_ACKED;
                end
                SRC_ACKED: if (!ack_sync) begin
                    {src_rsp_rdata, src_rsp_err} <= rsp_launch;
                    src_rsp_valid <= 1'b1;
                    src_state     <= SRC_RSP;
                end
                SRC_RSP: if (src_rsp_ready) begin
                    src_rsp_valid <= 1'b0;
                    src_busy      <= 1'b0;
                    src_req_ready <= 1'b1;
                    src_state     <= SRC_IDLE;
                end
                default: src_state <= SRC_IDLE;
            endcase
        end
    end

    // APB address phase and the response launch share the dst capture points of the FSM below.
    always_ff @(posedge clk_dst) begin
        if (dst_state == DST_IDLE && req_sync && !ack) begin
            {dst_paddr, dst_pwdata, dst_pwrite} <= req_launch;
        end
        if (dst_state == DST_ACCESS && dst_pready) begin
            rsp_launch <= {dst_prdata, dst_pslverr};
        end
    end

    always_ff @(posedge clk_dst or negedge rst_n_dst) begin
        if (!rst_n_dst) begin
            dst_state   <= DST_IDLE;
            ack         <= 1'b0;
            dst_psel    <= 1'b0;
            dst_penable <= 1'b0;
        end else begin
            case (dst_state)
                DST_IDLE: if (req_sync && !ack) begin
                    ack       <= 1'b1;
                    dst_psel  <= 1'b1;
                    dst_state <= DST_SETUP;
                end
                DST_SETUP: begin
                    dst_penable <= 1'b1;
                    dst_state   <= DST_ACCESS;
                end
                DST_ACCESS: if (dst_pready) begin
                    dst_psel    <= 1'b0;
                    dst_penable <= 1'b0;
                    dst_state   <= DST_HOLD;
                end
                DST_HOLD: if (!req_sync) begin
                    ack       <= 1'b0;
                    dst_state <= DST_IDLE;
                end
                default: dst_state <= DST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hazard3_dmi_async_initiator.sv
// Bench: requester driver, APB memory model on the dst side, and a per-cycle src-side response checker.
module tb_hazard3_dmi_async_initiator;

    localparam int BUDGET = 3000;

    int hp_src = 5;
    int hp_dst = 7;

    logic        clk_src = 1'b0;
    logic        clk_dst = 1'b0;
    logic        rst_n_src = 1'b0;
    logic        rst_n_dst = 1'b0;
    logic        src_req_valid = 1'b0;
    logic        src_req_ready;
    logic        src_req_write = 1'b0;
    logic [7:0]  src_req_addr = '0;
    logic [31:0] src_req_wdata = '0;
    logic        src_rsp_valid;
    logic        src_rsp_ready = 1'b0;
    logic [31:0] src_rsp_rdata;
    logic        src_rsp_err;
    logic        src_busy;
    logic        dst_psel;
    logic        dst_penable;
    logic        dst_pwrite;
    logic [7:0]  dst_paddr;
    logic [31:0] dst_pwdata;
    logic [31:0] dst_prdata = '0;
    logic        dst_pready = 1'b0;
    logic        dst_pslverr = 1'b0;

    hazard3_dmi_async_initiator dut (
        .clk_src       (clk_src),
        .rst_n_src     (rst_n_src),
        .clk_dst       (clk_dst),
        .rst_n_dst     (rst_n_dst),
        .src_req_valid (src_req_valid),
        .src_req_ready (src_req_ready),
        .src_req_write (src_req_write),
        .src_req_addr  (src_req_addr),
        .src_req_wdata (src_req_wdata),
        .src_rsp_valid (src_rsp_valid),
        .src_rsp_ready (src_rsp_ready),
        .src_rsp_rdata (src_rsp_rdata),
        .src_rsp_err   (src_rsp_err),
        .src_busy      (src_busy),
        .dst_psel      (dst_psel),
        .dst_penable   (dst_penable),
        .dst_pwrite    (dst_pwrite),
        .dst_paddr     (dst_paddr),
        .dst_pwdata    (dst_pwdata),
        .dst_prdata    (dst_prdata),
        .dst_pready    (dst_pready),
        .dst_pslverr   (dst_pslverr)
    );

    initial forever #(hp_src) clk_src = ~clk_src;
    initial forever #(hp_dst) clk_dst = ~clk_dst;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Requester-side reference memory and DM-side memory evolve independently.
    logic [31:0] ref_mem [256];
    logic [31:0] dm_mem  [256];

    function automatic logic [31:0] wr_junk(input logic [7:0] a, input logic [31:0] d);
        return {a, a, 16'hA5C3} ^ d;
    endfunction

    // Current transaction as the requester issued it; the DM model checks against this.
    logic        cur_write;
    logic [7:0]  cur_addr;
    logic [31:0] cur_wdata;
    int          waits_cfg = 0;
    logic        err_cfg = 1'b0;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        in_flight = 1'b0;
    bit          mon_en = 1'b0;

    int          apb_count = 0;
    logic [7:0]  last_paddr;
    logic [31:0] last_pwdata;
    logic        last_pwrite;
    int          last_psel_cycles;
    logic [31:0] last_rsp_rdata;
    logic        last_rsp_err;

    // APB completer: decides pready at the falling edge so the DUT samples it on the next rising edge.
    int  wait_left = 0;
    int  acc_cycles = 0;
    bit  in_xfer = 1'b0;
    always @(negedge clk_dst) begin
        if (!rst_n_dst) begin
            dst_pready = 1'b0;
            in_xfer = 1'b0;
        end else if (dst_psel && !dst_penable) begin
            chk("setup_once", {63'd0, in_xfer}, 64'd0);
            in_xfer = 1'b1;
            acc_cycles = 0;
            wait_left = waits_cfg;
            dst_pready = 1'b0;
        end else if (dst_psel && dst_penable) begin
            acc_cycles++;
            if (wait_left > 0) begin
                wait_left--;
                dst_pready = 1'b0;
            end else begin
                dst_pready  = 1'b1;
                dst_pslverr = err_cfg;
                dst_prdata  = dst_pwrite ? wr_junk(dst_paddr, dst_pwdata) : dm_mem[dst_paddr];
                if (dst_pwrite && !err_cfg) dm_mem[dst_paddr] = dst_pwdata;
                apb_count++;
                last_paddr = dst_paddr;
                last_pwdata = dst_pwdata;
                last_pwrite = dst_pwrite;
                last_psel_cycles = acc_cycles + 1;
                chk("apb_addr", {56'd0, dst_paddr}, {56'd0, cur_addr});
                chk("apb_write", {63'd0, dst_pwrite}, {63'd0, cur_write});
                if (cur_write) chk("apb_wdata", {32'd0, dst_pwdata}, {32'd0, cur_wdata});
                chk("acc_cycles", acc_cycles, waits_cfg + 1);
                in_xfer = 1'b0;
            end
        end else begin
            dst_pready = 1'b0;
            chk("penable_wo_psel", {63'd0, dst_penable}, 64'd0);
        end
    end

    // Src-side compare process, every cycle.
    always @(negedge clk_src) begin
        if (mon_en) begin
            chk("busy", {63'd0, src_busy}, {63'd0, in_flight});
            chk("req_ready", {63'd0, src_req_ready}, {63'd0, !in_flight});
            if (src_rsp_valid) begin
                chk("rsp_in_flight", 64'd1, {63'd0, in_flight});
                chk("rsp_rdata", {32'd0, src_rsp_rdata}, {32'd0, exp_rdata});
                chk("rsp_err", {63'd0, src_rsp_err}, {63'd0, exp_err});
            end
        end
    end

    task automatic do_xfer(input logic wr, input logic [7:0] a, input logic [31:0] d,
                           input int waits, input logic err, input int stall);
        int n;
        int apb_before;
        @(negedge clk_src);
        cur_write = wr; cur_addr = a; cur_wdata = d;
        waits_cfg = waits; err_cfg = err;
        exp_err   = err;
        exp_rdata = wr ? wr_junk(a, d) : ref_mem[a];
        if (wr && !err) ref_mem[a] = d;
        apb_before = apb_count;
        n = 0;
        while (!src_req_ready && n < BUDGET) begin @(negedge clk_src); n++; end
        if (n >= BUDGET) begin chk("accept_timeout", 64'd1, 64'd0); return; end
        src_req_valid = 1'b1; src_req_write = wr; src_req_addr = a; src_req_wdata = d;
        @(posedge clk_src); #1;
        in_flight = 1'b1;
        src_req_valid = 1'b0;
        @(negedge clk_src);
        n = 0;
        while (!src_rsp_valid && n < BUDGET) begin @(negedge clk_src); n++; end
        if (n >= BUDGET) begin chk("rsp_timeout", 64'd1, 64'd0); return; end
        if (stall > 0) begin
            n = apb_count;
            repeat (stall) @(negedge clk_src);
            chk("stall_no_apb", apb_count, n);
            chk("stall_valid", {63'd0, src_rsp_valid}, 64'd1);
            chk("stall_req_ready", {63'd0, src_req_ready}, 64'd0);
        end
        last_rsp_rdata = src_rsp_rdata;
        last_rsp_err   = src_rsp_err;
        src_rsp_ready = 1'b1;
        @(posedge clk_src); #1;
        in_flight = 1'b0;
        src_rsp_ready = 1'b0;
        chk("n_xfer", apb_count - apb_before, 1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = 32'h0101_0101 * i;
            dm_mem[i]  = 32'h0101_0101 * i;
        end
        ref_mem[8'h11] = 32'h1234_5678;
        dm_mem[8'h11]  = 32'h1234_5678;

        repeat (4) @(negedge clk_src);
        rst_n_src = 1'b1;
        rst_n_dst = 1'b1;
        @(negedge clk_src);
        chk("rst_req_ready", {63'd0, src_req_ready}, 64'd1);
        chk("rst_rsp_valid", {63'd0, src_rsp_valid}, 64'd0);
        chk("rst_rsp_rdata", {32'd0, src_rsp_rdata}, 64'd0);
        chk("rst_rsp_err", {63'd0, src_rsp_err}, 64'd0);
        chk("rst_busy", {63'd0, src_busy}, 64'd0);
        chk("rst_psel", {63'd0, dst_psel}, 64'd0);
        chk("rst_penable", {63'd0, dst_penable}, 64'd0);
        mon_en = 1'b1;

        do_xfer(1'b1, 8'h10, 32'hDEAD_BEEF, 0, 1'b0, 0);
        chk("wr_paddr_lit", {56'd0, last_paddr}, 64'h10);
        chk("wr_pwdata_lit", {32'd0, last_pwdata}, 64'hDEAD_BEEF);
        chk("wr_pwrite_lit", {63'd0, last_pwrite}, 64'd1);
        chk("wr_psel_cycles_lit", last_psel_cycles, 2);
        chk("wr_err_lit", {63'd0, last_rsp_err}, 64'd0);

        do_xfer(1'b0, 8'h11, 32'h0, 3, 1'b0, 0);
        chk("rd_rdata_lit", {32'd0, last_rsp_rdata}, 64'h1234_5678);
        chk("rd_err_lit", {63'd0, last_rsp_err}, 64'd0);
        chk("rd_psel_cycles_lit", last_psel_cycles, 5);

        do_xfer(1'b0, 8'h20, 32'h0, 1, 1'b1, 0);
        chk("slverr_lit", {63'd0, last_rsp_err}, 64'd1);
        do_xfer(1'b0, 8'h10, 32'h0, 0, 1'b0, 0);
        chk("after_err_rdata_lit", {32'd0, last_rsp_rdata}, 64'hDEAD_BEEF);
        chk("after_err_err_lit", {63'd0, last_rsp_err}, 64'd0);

        do_xfer(1'b0, 8'h11, 32'h0, 2, 1'b0, 50);
        chk("stall_rdata_lit", {32'd0, last_rsp_rdata}, 64'h1234_5678);

        for (int phase = 0; phase < 2; phase++) begin
            hp_src = (phase == 0) ? 5 : 35;
            hp_dst = (phase == 0) ? 35 : 5;
            for (int k = 0; k < 100; k++) begin
                do_xfer(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), $urandom,
                        $urandom_range(0, 2), 1'b0, 0);
            end
        end
        hp_src = 5;
        hp_dst = 7;

        fork
            begin
                rst_n_dst = 1'b0;
                do_xfer(1'b1, 8'h33, 32'hCAFE_F00D, 1, 1'b0, 0);
            end
            begin
                repeat (30) @(negedge clk_src);
                chk("dst_rst_no_apb_psel", {63'd0, dst_psel}, 64'd0);
                rst_n_dst = 1'b1;
            end
        join
        chk("dst_rst_paddr_lit", {56'd0, last_paddr}, 64'h33);
        do_xfer(1'b0, 8'h33, 32'h0, 0, 1'b0, 0);
        chk("dst_rst_readback_lit", {32'd0, last_rsp_rdata}, 64'hCAFE_F00D);

        repeat (5) @(negedge clk_src);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
